rotor_inverse: RTL and testbench

//  Return-path (inverse) rotor for the enigma datapath: maps a letter entering a rotor's output

---
 rtl/rotor_inverse.sv | 238 +++++++++++++++++++++++
 tb/tb_rotor_inverse.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotor_inverse.sv
// rotor_inverse: return-path rotor for the enigma datapath.
// Maps a letter arriving on a rotor's output side back to its input side. On set, the forward
// wiring table is latched and its inverse is built over 26 cycles, one entry per cycle. Letters
// are then served one at a time through a valid/done handshake with a programmable delay.
// Non-letters pass straight through without advancing the rotor position.
//
// Optional feature: define WIRING_CHECK_EN to track a seen-mask during the build. A malformed
// table (entry outside 'A'..'Z' or a duplicate letter) raises err and keeps ready low.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   set      latch offset/delay/idx_in and start the inverse-table build (any state)
//   offset   rotation step per letter; 26..31 act as offset-26
//   delay    wait cycles per character; 0 acts as 1
//   idx_in   forward wiring table, letter i at [200-8*i +: 8]
//   valid    one-cycle character request, honoured only when idle and ready
//   din      ASCII character sampled with an accepted valid
//   dout     mapped character while done=1, otherwise 0
//   done     one-cycle result pulse
//   ready    inverse table built, requests accepted
//   busy     building the table or waiting out the delay
//   err      malformed wiring table (only with WIRING_CHECK_EN, else 0)
module rotor_inverse #(
    parameter int unsigned NLET = 26,
    parameter int unsigned BASE = 65
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         set,
    input  logic [4:0]   offset,
    input  logic [7:0]   delay,
    input  logic [207:0] idx_in,
    input  logic         valid,
    input  logic [7:0]   din,
    output logic [7:0]   dout,
    output logic         done,
    output logic         ready,
    output logic         busy,
    output logic         err
);

    localparam logic [7:0] Base8   = 8'(BASE);
    localparam logic [7:0] LastLet = 8'(BASE + NLET - 1);
    localparam logic [4:0] LastK   = 5'(NLET - 1);
    localparam logic [4:0] Nlet5   = 5'(NLET);

    typedef enum logic [1:0] {StIdle, StBuild, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic [4:0]     k_q, k_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [4:0]     pos_q, pos_d;
    logic [4:0]     off_q, off_d;
    logic [7:0]     dly_q, dly_d;
    logic [207:0]   tbl_q, tbl_d;
    logic [7:0]     din_q, din_d;
    logic [4:0]     inv_q [NLET];
    logic [4:0]     inv_d [NLET];
    logic [7:0]     dout_q, dout_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
`ifdef WIRING_CHECK_EN
    logic [25:0]    seen_q, seen_d;
    logic           bad_q, bad_d;
`endif

    // Table entry consumed by the current build cycle.
    logic [7:0] build_c;
    logic       build_ok;
    logic [4:0] build_idx;
    // Lookup for the pending character.
    logic       din_letter;
    logic [4:0] map_x;
    logic [4:0] inv_x;
    logic [4:0] map_rel;
    logic [5:0] pos_sum;
    logic [4:0] pos_next;

    always_comb begin
        build_c   = tbl_q[207 - 8 * int'(k_q) -: 8];
        build_ok  = (build_c >= Base8) && (build_c <= LastLet);
        build_idx = build_ok ? 5'(build_c - Base8) : 5'd0;

        din_letter = (din_q >= Base8) && (din_q <= LastLet);
        map_x      = din_letter ? 5'(din_q - Base8) : 5'd0;
        inv_x      = inv_q[map_x];
        // 5-bit wraparound makes inv_x + 26 - pos exact when inv_x < pos.
        map_rel    = (inv_x >= pos_q) ? (inv_x - pos_q) : (inv_x + Nlet5 - pos_q);

        pos_sum  = {1'b0, pos_q} + {1'b0, off_q};
        pos_next = (pos_sum >= 6'(NLET)) ? 5'(pos_sum - 6'(NLET)) : pos_sum[4:0];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        off_d   = off_q;
        dly_d   = dly_q;
        tbl_d   = tbl_q;
        din_d   = din_q;
        inv_d   = inv_q;
        dout_d  = 8'h00;
        done_d  = 1'b0;
        ready_d = ready_q;
        err_d   = err_q;
`ifdef WIRING_CHECK_EN
        seen_d  = seen_q;
        bad_d   = bad_q;
`endif

        if (set) begin
            // set overrides everything, including a simultaneous valid.
            off_d   = (offset >= Nlet5) ? (offset - Nlet5) : offset;
            dly_d   = (delay == 8'd0) ? 8'd1 : delay;
            tbl_d   = idx_in;
            pos_d   = 5'd0;
            ready_d = 1'b0;
            err_d   = 1'b0;
            k_d     = 5'd0;
            state_d = StBuild;
`ifdef WIRING_CHECK_EN
            seen_d  = '0;
            bad_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid && ready_q) begin
                        din_d   = din;
                        cnt_d   = 8'd0;
                        state_d = StWait;
                    end
                end
                StBuild: begin
                    // Out-of-range entries are skipped so a bad table cannot index outside inv.
                    if (build_ok) begin
                        inv_d[build_idx] = k_q;
                    end
`ifdef WIRING_CHECK_EN
                    if (!build_ok) begin
                        bad_d = 1'b1;
                    end else begin
                        if (seen_q[build_idx]) begin
                            bad_d = 1'b1;
                        end
                        seen_d[build_idx] = 1'b1;
                    end
`endif
                    if (k_q == LastK) begin
                        state_d = StIdle;
`ifdef WIRING_CHECK_EN
                        ready_d = !bad_d;
                        err_d   = bad_d;
`else
                        ready_d = 1'b1;
                        err_d   = 1'b0;
`endif
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
                StWait: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == dly_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        dout_d  = din_letter ? (8'(map_rel) + Base8) : din_q;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    if (din_letter) begin
                        pos_d = pos_next;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StBuild) || (state_d == StWait);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= 5'd0;
            cnt_q   <= 8'd0;
            pos_q   <= 5'd0;
            off_q   <= 5'd0;
            dly_q   <= 8'd1;
            tbl_q   <= '0;
            din_q   <= 8'h00;
            for (int i = 0; i < int'(NLET); i++) begin
                inv_q[i] <= 5'd0;
            end
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WIRING_CHECK_EN
            seen_q  <= '0;
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            off_q   <= off_d;
            dly_q   <= dly_d;
            tbl_q   <= tbl_d;
            din_q   <= din_d;
            inv_q   <= inv_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef WIRING_CHECK_EN
            seen_q  <= seen_d;
            bad_q   <= bad_d;
`endif
        end
    end

    assign dout  = dout_q;
    assign done  = done_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_rotor_inverse.sv
// Testbench for rotor_inverse: directed scenarios plus random permutation tables, checked
// against a reference that searches the forward table for each letter.
module tb_rotor_inverse;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         set = 1'b0;
    logic [4:0]   offset = '0;
    logic [7:0]   delay = '0;
    logic [207:0] idx_in = '0;
    logic         valid = 1'b0;
    logic [7:0]   din = '0;
    logic [7:0]   dout;
    logic         done;
    logic         ready;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    rotor_inverse dut (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (set),
        .offset  (offset),
        .delay   (delay),
        .idx_in  (idx_in),
        .valid   (valid),
        .din     (din),
        .dout    (dout),
        .done    (done),
        .ready   (ready),
        .busy    (busy),
        .err     (err)
    );

    int n_checks = 0;
    int n_fails = 0;

    // Reference state: forward table, rotor position, effective offset and delay.
    logic [7:0] tbl [26];
    int         m_pos;
    int         m_off;
    int         m_dly;
    logic [7:0] last_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [207:0] pack_tbl();
        logic [207:0] v;
        v = '0;
        for (int i = 0; i < 26; i++) v[207 - 8 * i -: 8] = tbl[i];
        return v;
    endfunction

    function automatic bit is_letter(input logic [7:0] ch);
        return (ch >= 8'd65) && (ch <= 8'd90);
    endfunction

    // Inverse lookup: position i where the forward table holds ch, shifted back by pos.
    function automatic logic [7:0] model_map(input logic [7:0] ch);
        if (!is_letter(ch)) return ch;
        for (int i = 0; i < 26; i++) begin
            if (tbl[i] == ch) return 8'((((i - m_pos) % 26) + 26) % 26 + 65);
        end
        return 8'h00;
    endfunction

    task automatic fill_identity();
        for (int i = 0; i < 26; i++) tbl[i] = 8'(65 + i);
    endtask

    task automatic fill_random_perm();
        logic [7:0] t;
        int j;
        fill_identity();
        for (int i = 25; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = tbl[i];
            tbl[i] = tbl[j];
            tbl[j] = t;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_ready"}, 32'(ready), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    // Starts at a negedge. Loads the current table; a valid is pulsed mid-build to show it is dropped.
    task automatic do_set(input int off, input int dly, input bit ok, input bit with_valid);
        bit saw_done;
        bit saw_ready;
        set    = 1'b1;
        valid  = with_valid;
        din    = 8'h41;
        offset = 5'(off);
        delay  = 8'(dly);
        idx_in = pack_tbl();
        @(negedge clk);
        set   = 1'b0;
        valid = 1'b0;
        m_pos = 0;
        m_off = (off >= 26) ? off - 26 : off;
        m_dly = (dly == 0) ? 1 : dly;
        check("set_busy", 32'(busy), 32'h1);
        check("set_ready", 32'(ready), 32'h0);
        check("set_err", 32'(err), 32'h0);
        saw_done  = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            valid = (i == 5);
            din   = 8'h41;
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (ready) saw_ready = 1'b1;
        end
        valid = 1'b0;
        check("build_no_done", 32'(saw_done), 32'h0);
        check("build_ready_early", 32'(saw_ready), 32'h0);
        @(negedge clk);
        check("build_ready", 32'(ready), 32'(ok));
        check("build_err", 32'(err), 32'(!ok));
        check("build_busy_end", 32'(busy), 32'h0);
        if (!ok) begin
            valid = 1'b1;
            din   = 8'h41;
            @(negedge clk);
            valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("post_build_done", 32'(done), 32'h0);
        check("post_build_busy", 32'(busy), 32'h0);
    endtask

    // Starts at a negedge; returns at the negedge after the done pulse (DUT back in IDLE).
    task automatic send(input logic [7:0] ch);
        logic [7:0] exp;
        int edges;
        exp   = model_map(ch);
        valid = 1'b1;
        din   = ch;
        @(negedge clk);
        valid = 1'b0;
        din   = 8'h00;
        edges = 1;
        while (!done && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'(m_dly + 1));
        check("dout", 32'(dout), 32'(exp));
        last_dout = dout;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'h0);
        check("dout_idle", 32'(dout), 32'h0);
        if (is_letter(ch)) m_pos = (m_pos + m_off) % 26;
    endtask

    initial begin
        string enig;
        bit saw_done;
        int n;
        logic [7:0] ch;

        m_pos = 0;
        m_off = 0;
        m_dly = 1;
        last_dout = '0;

        // Power-on reset.
        #2 reset_n = 1'b0;
        #1 check_idle_zero("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("por_rel");

        // Identity table, offset 0, delay 3: 'C' -> 'C' with four-edge latency.
        fill_identity();
        do_set(0, 3, 1'b1, 1'b0);
        send(8'h43);
        check("t2_C", 32'(last_dout), 32'h43);

        // Reset in the middle of a WAIT.
        do_set(0, 20, 1'b1, 1'b0);
        valid = 1'b1;
        din   = 8'h41;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_wait_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1 check_idle_zero("rst_low");
        @(negedge clk);
        check_idle_zero("rst_low2");
        reset_n = 1'b1;
        saw_done = 1'b0;
        valid = 1'b1;
        din   = 8'h41;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy || ready) saw_done = 1'b1;
        end
        check_idle_zero("rst_rel");
        check("rst_rel_quiet", 32'(saw_done), 32'h0);

        // Historical rotor I wiring, offset 0, delay 1.
        enig = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        for (int i = 0; i < 26; i++) tbl[i] = enig[i];
        do_set(0, 1, 1'b1, 1'b0);
        send(8'h45);
        check("t3_E", 32'(last_dout), 32'h41);
        send(8'h4B);
        check("t3_K", 32'(last_dout), 32'h42);
        send(8'h4A);
        check("t3_J", 32'(last_dout), 32'h5A);

        // Identity table, offset 1 (given as 27): rotation and wrap, non-letter passthrough.
        fill_identity();
        do_set(27, 0, 1'b1, 1'b0);
        send(8'h41);
        check("t4_A0", 32'(last_dout), 32'h41);
        send(8'h41);
        check("t4_A1", 32'(last_dout), 32'h5A);
        send(8'h41);
        check("t4_A2", 32'(last_dout), 32'h59);
        send(8'h41);
        check("t4_A3", 32'(last_dout), 32'h58);
        send(8'h40);
        check("t4_at", 32'(last_dout), 32'h40);
        send(8'h41);
        check("t4_A4", 32'(last_dout), 32'h57);

        // Position wraps 25 -> 0 with offset 25 then 1 step... use offset 25: pos 0,25,24.
        do_set(25, 2, 1'b1, 1'b0);
        send(8'h41);
        check("wrap_A0", 32'(last_dout), 32'h41);
        send(8'h41);
        check("wrap_A1", 32'(last_dout), 32'h42);

        // set during WAIT, together with a valid: the pending char is dropped.
        do_set(0, 10, 1'b1, 1'b0);
        valid = 1'b1;
        din   = 8'h44;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        do_set(3, 2, 1'b1, 1'b1);
        send(8'h42);
        check("t5_B", 32'(last_dout), 32'h42);
        send(8'h42);
        check("t5_B2", 32'(last_dout), 32'h59);

`ifdef WIRING_CHECK_EN
        // Duplicate 'A' entry: err set, ready held low, valid ignored; a good set clears err.
        fill_identity();
        tbl[1] = 8'h41;
        do_set(0, 1, 1'b0, 1'b0);
        check("t6_err_hold", 32'(err), 32'h1);
        check("t6_ready_hold", 32'(ready), 32'h0);
        tbl[1] = 8'h42;
        tbl[7] = 8'h20;
        do_set(0, 1, 1'b0, 1'b0);
        fill_identity();
        do_set(0, 1, 1'b1, 1'b0);
        check("t6_err_clr", 32'(err), 32'h0);
        send(8'h5A);
        check("t6_Z", 32'(last_dout), 32'h5A);
`endif

        // Random permutations, offsets, delays and characters.
        for (int r = 0; r < 5; r++) begin
            fill_random_perm();
            do_set(int'($urandom_range(0, 31)), int'($urandom_range(0, 4)), 1'b1, 1'b0);
            n = 10 + int'($urandom_range(0, 6));
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 5) == 0) ch = 8'($urandom_range(32, 126));
                else ch = 8'(65 + $urandom_range(0, 25));
                send(ch);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
